// File: rtl/timer_pkg.sv
// Shared constants for the stopwatch/countdown timer.
// State encoding plus default digit geometry of the counter cascade.
package timer_pkg;

   localparam int DIGITS_DEF      = 4;
   localparam int DIGIT_WIDTH_DEF = 4;

   localparam logic [2:0] ST_CLEARING = 3'd0;
   localparam logic [2:0] ST_IDLE     = 3'd1;
   localparam logic [2:0] ST_RUNNING  = 3'd2;
   localparam logic [2:0] ST_PAUSED   = 3'd3;
   localparam logic [2:0] ST_EXPIRED  = 3'd4;

   typedef enum logic [2:0] {
      CLEARING = ST_CLEARING,
      IDLE     = ST_IDLE,
      RUNNING  = ST_RUNNING,
      PAUSED   = ST_PAUSED,
      EXPIRED  = ST_EXPIRED
   } state_t;

endpackage

// File: rtl/edge_sync.sv
// Button conditioner: SYNC_STAGES-deep synchronizer plus rising-edge pulse.
// Ports: clk, rst_n (async low), raw (async button), pulse (one cycle per press).
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic pulse
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         last_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         last_q <= sync_q[SYNC_STAGES-1];
      end
   end

   // Held buttons stay high in sync_q, so only the 0->1 step fires.
   assign pulse = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/timer_control.sv
// Sequencer for the cascaded counter chain: buttons, clear pulse, alarm compare.
// Ports: inputClock, nReset, startStop, clear, alarmEnable, target, count -> pause, counterReset_n, alarm, state.
module timer_control
   import timer_pkg::*;
#(
   parameter int DIGITS       = DIGITS_DEF,
   parameter int DIGIT_WIDTH  = DIGIT_WIDTH_DEF,
   parameter int SYNC_STAGES  = 2,
   parameter int CLEAR_CYCLES = 2
) (
   input  logic                          inputClock,
   input  logic                          nReset,
   input  logic                          startStop,
   input  logic                          clear,
   input  logic                          alarmEnable,
   input  logic [DIGITS*DIGIT_WIDTH-1:0] target,
   input  logic [DIGITS*DIGIT_WIDTH-1:0] count,
   output logic                          pause,
   output logic                          counterReset_n,
   output logic                          alarm,
   output logic [2:0]                    state
);

   localparam int CW = $clog2(CLEAR_CYCLES + 1);
   localparam logic [CW-1:0] CLR_LOAD = CW'(CLEAR_CYCLES);
   localparam logic [CW-1:0] CLR_ONE  = CW'(1);

   logic          ss_pulse;
   logic          clr_pulse;
   logic          match;
   state_t        state_q;
   state_t        state_nxt;
   logic [CW-1:0] clr_cnt;
   logic [CW-1:0] clr_cnt_nxt;

   edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_ss_sync (
      .clk  (inputClock),
      .rst_n(nReset),
      .raw  (startStop),
      .pulse(ss_pulse)
   );

   edge_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_clr_sync (
      .clk  (inputClock),
      .rst_n(nReset),
      .raw  (clear),
      .pulse(clr_pulse)
   );

   // All-zero target means "no alarm programmed".
   assign match = alarmEnable
                & (count == target)
                & (target != '0);

   always_comb begin
      state_nxt   = state_q;
      clr_cnt_nxt = clr_cnt;
      unique case (state_q)
         CLEARING: begin
            if (clr_cnt <= CLR_ONE) state_nxt = IDLE;
            else clr_cnt_nxt = clr_cnt - CLR_ONE;
         end
         IDLE: begin
            if (clr_pulse)     state_nxt = CLEARING;
            else if (ss_pulse) state_nxt = RUNNING;
         end
         RUNNING: begin
            if (clr_pulse)     state_nxt = CLEARING;
            else if (match)    state_nxt = EXPIRED;
            else if (ss_pulse) state_nxt = PAUSED;
         end
         PAUSED: begin
            if (clr_pulse)     state_nxt = CLEARING;
            else if (ss_pulse) state_nxt = RUNNING;
         end
         EXPIRED: begin
            if (clr_pulse | ss_pulse) state_nxt = CLEARING;
         end
         default: state_nxt = CLEARING;
      endcase
      // Every fresh entry into CLEARING gets a full-width clear pulse.
      if (state_nxt == CLEARING && state_q != CLEARING)
         clr_cnt_nxt = CLR_LOAD;
   end

   // Outputs decode next-state so they move on the same edge as state.
   always_ff @(posedge inputClock or negedge nReset) begin
      if (!nReset) begin
         state_q        <= CLEARING;
         clr_cnt        <= CLR_LOAD;
         pause          <= 1'b1;
         counterReset_n <= 1'b0;
         alarm          <= 1'b0;
      end else begin
         state_q        <= state_nxt;
         clr_cnt        <= clr_cnt_nxt;
         pause          <= (state_nxt != RUNNING);
         counterReset_n <= (state_nxt != CLEARING);
         alarm          <= (state_nxt == EXPIRED);
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_timer_control.sv
// Scoreboard bench for timer_control with a behavioural counter chain.
// Model predicts outputs per rising edge; monitor pops and compares.
module tb_timer_control;

   localparam int S  = 2;
   localparam int CC = 2;
   localparam int ST_CLR = 0;
   localparam int ST_IDL = 1;
   localparam int ST_RUN = 2;
   localparam int ST_PAU = 3;
   localparam int ST_EXP = 4;

   typedef struct packed {
      logic [2:0] st;
      logic       p;
      logic       rn;
      logic       al;
   } exp_t;

   logic        clk = 1'b0;
   logic        nReset = 1'b0;
   logic        startStop = 1'b0;
   logic        clear = 1'b0;
   logic        alarmEnable = 1'b0;
   logic [15:0] target = '0;
   logic [15:0] count = '0;
   logic        pause;
   logic        counterReset_n;
   logic        alarm;
   logic [2:0]  state;

   int n_checks = 0;
   int n_pass   = 0;
   exp_t expq[$];

   timer_control #(
      .DIGITS(4),
      .DIGIT_WIDTH(4),
      .SYNC_STAGES(S),
      .CLEAR_CYCLES(CC)
   ) dut (
      .inputClock    (clk),
      .nReset        (nReset),
      .startStop     (startStop),
      .clear         (clear),
      .alarmEnable   (alarmEnable),
      .target        (target),
      .count         (count),
      .pause         (pause),
      .counterReset_n(counterReset_n),
      .alarm         (alarm),
      .state         (state)
   );

   always #5 clk = ~clk;

   // Counter cascade: digits chained as one binary count, stepping on the falling edge.
   always @(negedge clk or negedge counterReset_n) begin
      if (!counterReset_n) count <= '0;
      else if (!pause) count <= count + 16'd1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
   endtask

   // Reference model: button seen as a pulse S+1 edges after it is first sampled high.
   int m_st = ST_CLR;
   int m_left = CC;
   bit ss_h[$];
   bit cl_h[$];

   always @(posedge clk) begin
      bit ssp, clp, hit;
      exp_t e;
      if (!nReset) begin
         m_st = ST_CLR;
         m_left = CC;
         ss_h = {};
         cl_h = {};
         repeat (S + 1) begin
            ss_h.push_back(1'b0);
            cl_h.push_back(1'b0);
         end
      end else begin
         ssp = ss_h[S-1] && !ss_h[S];
         clp = cl_h[S-1] && !cl_h[S];
         hit = alarmEnable && (target != 0) && (count == target);
         if (m_st == ST_CLR) begin
            m_left--;
            if (m_left == 0) m_st = ST_IDL;
         end else if (clp) begin
            m_st = ST_CLR;
            m_left = CC;
         end else if (m_st == ST_RUN && hit) begin
            m_st = ST_EXP;
         end else if (ssp) begin
            case (m_st)
               ST_IDL: m_st = ST_RUN;
               ST_RUN: m_st = ST_PAU;
               ST_PAU: m_st = ST_RUN;
               default: begin
                  m_st = ST_CLR;
                  m_left = CC;
               end
            endcase
         end
         ss_h.push_front(startStop);
         void'(ss_h.pop_back());
         cl_h.push_front(clear);
         void'(cl_h.pop_back());
      end
      e.st = 3'(m_st);
      e.p  = (m_st != ST_RUN);
      e.rn = (m_st != ST_CLR);
      e.al = (m_st == ST_EXP);
      expq.push_back(e);
   end

   // Monitor: compare DUT outputs just after each rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (expq.size() == 0) begin
         chk("scoreboard_empty", 32'(expq.size()), 32'd1);
      end else begin
         e = expq.pop_front();
         chk("outputs{state,pause,rstn,alarm}",
             32'({state, pause, counterReset_n, alarm}), 32'(e));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic press_ss(input int hold);
      startStop = 1'b1;
      cyc(hold);
      startStop = 1'b0;
      cyc(4);
   endtask

   task automatic press_clr(input int hold);
      clear = 1'b1;
      cyc(hold);
      clear = 1'b0;
      cyc(4);
   endtask

   task automatic do_reset(input int len);
      nReset = 1'b0;
      #1;
      chk("reset_immediate", 32'({state, pause, counterReset_n, alarm}), 32'(6'b000_1_0_0));
      cyc(len);
      nReset = 1'b1;
   endtask

   initial begin
      cyc(3);
      nReset = 1'b1;
      cyc(5);
      chk("idle_after_reset", 32'(state), 32'(ST_IDL));

      // Run with target=0: never expires.
      alarmEnable = 1'b1;
      target = 16'h0000;
      press_ss(1);
      chk("running", 32'(state), 32'(ST_RUN));
      cyc(30);
      // Long hold: exactly one pause.
      press_ss(50);
      chk("paused_after_hold", 32'(state), 32'(ST_PAU));

      // Clear and start/stop together in PAUSED.
      startStop = 1'b1;
      clear = 1'b1;
      cyc(2);
      startStop = 1'b0;
      clear = 1'b0;
      cyc(8);
      chk("clear_priority_idle", 32'(state), 32'(ST_IDL));

      // Alarm disabled while count passes target.
      alarmEnable = 1'b0;
      target = 16'h0005;
      press_ss(1);
      cyc(20);
      chk("no_expiry_disabled", 32'(state), 32'(ST_RUN));
      press_clr(1);
      cyc(4);

      // Expiry freezes the chain at target.
      alarmEnable = 1'b1;
      press_ss(1);
      cyc(100);
      chk("expired_alarm", 32'(alarm), 32'd1);
      chk("count_frozen", 32'(count), 32'h0005);

      // Start/stop in EXPIRED clears back to zero.
      press_ss(1);
      cyc(4);
      chk("count_cleared", 32'(count), 32'h0000);
      chk("idle_after_expire", 32'(state), 32'(ST_IDL));

      // Reset in the middle of a run.
      target = 16'h0000;
      press_ss(1);
      cyc(10);
      do_reset(3);
      cyc(5);

      // Randomized phase.
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 999));
         if (r < 60) startStop = ~startStop;
         else if (r < 80) clear = ~clear;
         else if (r < 100) alarmEnable = 1'($urandom_range(0, 1));
         else if (r < 115) begin
            if ($urandom_range(0, 3) == 0) target = '0;
            else target = 16'($urandom_range(1, 60));
         end else if (r < 118) begin
            do_reset(int'($urandom_range(1, 3)));
         end
         cyc(1);
      end

      startStop = 1'b0;
      clear = 1'b0;
      cyc(6);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/timer_control.md
# timer_control

Sequencing controller for the stopwatch/countdown timer's cascaded `Counter` chain. It converts raw start/stop and clear buttons into the chain's `pause` and active-low clear, and compares the concatenated digit counts against a programmable target. On a match it freezes the chain and raises `alarm`. It sits between the board buttons and the counter cascade; the lowest counter stage is clocked by `inputClock` on its falling edge.

## Interface
- `DIGITS`, default 4: number of cascaded counter digits.
- `DIGIT_WIDTH`, default 4: bits per digit, equal to each counter's `SIZE`.
- `SYNC_STAGES`, default 2: synchronizer depth on each button input, minimum 2.
- `CLEAR_CYCLES`, default 2: length of the chain-clear pulse in `inputClock` cycles, minimum 1.

Ports:
- `inputClock`, in, 1: system clock. The block uses the rising edge.
- `nReset`, in, 1: asynchronous, active-low reset.
- `startStop`, in, 1: raw button, active-high, asynchronous.
- `clear`, in, 1: raw button, active-high, asynchronous.
- `alarmEnable`, in, 1: enables the target compare.
- `target`, in, DIGITS*DIGIT_WIDTH: alarm time. The most significant digit is in the top bits.
- `count`, in, DIGITS*DIGIT_WIDTH: concatenated counter counts, same digit order as `target`.
- `pause`, out, 1: drives `pause` on every counter.
- `counterReset_n`, out, 1: drives `nReset` on every counter. Active-low.
- `alarm`, out, 1: high while in EXPIRED.
- `state`, out, 3: current state encoding, for debug and display.

## Operation
- **Button conditioning:** each button passes through SYNC_STAGES flops and then a rising-edge detector. The detector produces a one-cycle pulse, `ssPulse` or `clrPulse`. A held button produces exactly one pulse.
- **State machine:** five states. All outputs are registered and decoded from next-state, so they change on the same edge as `state`.
  - CLEARING: `pause`=1, `counterReset_n`=0. Stays for CLEAR_CYCLES cycles, then goes to IDLE. Button pulses are ignored in this state.
  - IDLE: `pause`=1, `counterReset_n`=1.
    - `clrPulse` → CLEARING.
    - else `ssPulse` → RUNNING.
  - RUNNING: `pause`=0.
    - `clrPulse` → CLEARING.
    - else match → EXPIRED.
    - else `ssPulse` → PAUSED.
  - PAUSED: `pause`=1.
    - `clrPulse` → CLEARING.
    - else `ssPulse` → RUNNING.
  - EXPIRED: `pause`=1, `alarm`=1. `clrPulse` or `ssPulse` → CLEARING.
- **Priority on simultaneous events:** clear > match > start/stop.
- **Match condition:** `alarmEnable`=1 and `count`==`target` and `target`≠0. An all-zero `target` disables the alarm. The compare is combinational and evaluated only in RUNNING.
- **Reset:** asynchronous assertion forces the following, regardless of the current state:
  - state = CLEARING
  - clear-cycle counter loaded with CLEAR_CYCLES
  - `pause`=1, `counterReset_n`=0, `alarm`=0
  - synchronizer and edge flops = 0
  
  After release the block completes the clear pulse and then enters IDLE.

## Timing
- **Button latency:** a raw rising edge captured at edge 1 produces its pulse after edge SYNC_STAGES. State and outputs update at edge SYNC_STAGES+1, which is 3 edges with the default depth.
- **Match sampling:** `count` changes on the falling edge and is sampled on the rising edge, giving a half-cycle setup window.
- **Freeze on match:** a match at rising edge N sets `pause`=1 at edge N. The following falling edge therefore does not advance the low digit, and `count` holds at `target`.
- **Clear pulse width:** `counterReset_n` is low for exactly CLEAR_CYCLES rising-edge periods after any clear, or after reset release.
- **No pulse loss:** no button pulse is lost outside CLEARING. A pulse arriving during CLEARING is discarded and not queued.

## Structure
- Package `timer_pkg` holds:
  - the 3-bit state encoding localparams: CLEARING=0, IDLE=1, RUNNING=2, PAUSED=3, EXPIRED=4;
  - the default digit width and count constants, shared with the counter cascade top.
- One sub-module, `edge_sync`, parameterized by SYNC_STAGES: synchronizer plus rising-edge pulse. It is instantiated twice.
- The top module contains the FSM, the clear-cycle counter and the comparator.

## Test plan
- **Reset:** assert `nReset`=0 mid-RUNNING. Expect immediately `pause`=1, `counterReset_n`=0, `alarm`=0, `state`=0. After release, `counterReset_n` stays low 2 cycles, then `state`=1.
- **Start/pause:** a `startStop` pulse in IDLE gives `pause`=0 exactly 3 edges later, `state`=2. A second press gives `state`=3, `pause`=1. Holding the button 50 cycles yields only one transition.
- **Clear priority:** `clear` and `startStop` rise on the same cycle in PAUSED. Expect `state`=0, then IDLE, never RUNNING.
- **Expiry:** `target`=16'h0005, `alarmEnable`=1, counters running. Expect `alarm`=1 and `pause`=1 on the first rising edge with `count`=0005. `count` stays 0005 for 100 cycles.
- **Alarm disabled:** with `target`=0, or with `alarmEnable`=0 and `count` passing the target, expect no expiry.
- **Exit from EXPIRED:** a `startStop` press in EXPIRED gives CLEARING, `counterReset_n` low 2 cycles, `count` returns to 0, `alarm`=0, then `state`=1.
